// File: rtl/watch_disp_pkg.sv
// Shared constants for the stopwatch display path: segment patterns, digit count, scan index.
package watch_disp_pkg;

   localparam int NUM_DIGITS = 6;

   // Active-high patterns, bit order {g,f,e,d,c,b,a}
   localparam logic [6:0] SEG_0     = 7'h3F;
   localparam logic [6:0] SEG_1     = 7'h06;
   localparam logic [6:0] SEG_2     = 7'h5B;
   localparam logic [6:0] SEG_3     = 7'h4F;
   localparam logic [6:0] SEG_4     = 7'h66;
   localparam logic [6:0] SEG_5     = 7'h6D;
   localparam logic [6:0] SEG_6     = 7'h7D;
   localparam logic [6:0] SEG_7     = 7'h07;
   localparam logic [6:0] SEG_8     = 7'h7F;
   localparam logic [6:0] SEG_9     = 7'h6F;
   localparam logic [6:0] SEG_DASH  = 7'h40;
   localparam logic [6:0] SEG_BLANK = 7'h00;

   typedef enum logic [2:0] {
      IDX_0 = 3'd0,
      IDX_1 = 3'd1,
      IDX_2 = 3'd2,
      IDX_3 = 3'd3,
      IDX_4 = 3'd4,
      IDX_5 = 3'd5
   } scan_idx_t;

   function automatic logic [6:0] seg_of(input logic [3:0] digit);
      logic [6:0] pat;
      pat = SEG_BLANK;
      case (digit)
         4'd0: pat = SEG_0;
         4'd1: pat = SEG_1;
         4'd2: pat = SEG_2;
         4'd3: pat = SEG_3;
         4'd4: pat = SEG_4;
         4'd5: pat = SEG_5;
         4'd6: pat = SEG_6;
         4'd7: pat = SEG_7;
         4'd8: pat = SEG_8;
         4'd9: pat = SEG_9;
         default: pat = SEG_BLANK;
      endcase
      return pat;
   endfunction

endpackage

// File: rtl/stop_display_scan_if.sv
// Time fields and blink enables in from the mode block; segment/digit pins out to the board.
interface stop_display_scan_if;
   logic [6:0] in_mm;
   logic [6:0] in_ss;
   logic [6:0] in_ms;
   logic [2:0] blink_en;
   logic [6:0] seg;
   logic       dp;
   logic [5:0] an;

   modport master (output in_mm, in_ss, in_ms, blink_en, input seg, dp, an);
   modport slave  (input in_mm, in_ss, in_ms, blink_en, output seg, dp, an);
endinterface

// File: rtl/bin7_to_bcd.sv
// 7-bit binary to two BCD digits by compare/subtract; values of 100 and up flag ovf.
module bin7_to_bcd (
   input  logic [6:0] i_bin,
   output logic [3:0] o_tens,
   output logic [3:0] o_ones,
   output logic       o_ovf
);

   always_comb begin
      o_tens = '0;
      o_ones = i_bin[3:0];
      o_ovf  = (i_bin >= 7'd100);
      // Highest matching decade wins; digits are don't-care when ovf is set
      for (int k = 1; k < 10; k++) begin
         if (i_bin >= 7'(10 * k)) begin
            o_tens = 4'(k);
            o_ones = 4'(i_bin - 7'(10 * k));
         end
      end
   end

endmodule

// File: rtl/stop_display_scan.sv
// Scans MM.SS.CC onto a 6-digit 7-segment display with per-field blink and registered pins.
//
//   state | meaning
//   IDX_0 | ms ones
//   IDX_1 | ms tens
//   IDX_2 | ss ones (dp lit)
//   IDX_3 | ss tens
//   IDX_4 | mm ones (dp lit)
//   IDX_5 | mm tens; snapshot reloads on the tick leaving this state
module stop_display_scan
   import watch_disp_pkg::*;
#(
   parameter int SCAN_DIV       = 2000,
   parameter int BLINK_DIV      = 500000,
   parameter bit SEG_ACTIVE_LOW = 1'b1
) (
   input  logic              clk_2MHz,
   input  logic              reset,
   stop_display_scan_if.slave bus
);

   // SCAN_DIV and BLINK_DIV must both be at least 2
   localparam int PW = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
   localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam logic [PW-1:0] SCAN_LAST  = PW'(SCAN_DIV - 1);
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
   localparam logic [6:0]    SEG_OFF    = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
   localparam logic [5:0]    AN_OFF     = SEG_ACTIVE_LOW ? 6'h3F : 6'h00;
   localparam logic          DP_OFF     = SEG_ACTIVE_LOW;

   logic [PW-1:0] r_presc;
   logic [BW-1:0] r_blink_cnt;
   logic          r_blink_hide;
   logic          r_frame_load;
   logic [6:0]    r_mm, r_ss, r_ms;
   logic [6:0]    r_seg;
   logic          r_dp;
   logic [5:0]    r_an;
   scan_idx_t     r_idx, w_idx_nxt;

   logic          w_tick;
   logic [6:0]    w_mm, w_ss, w_ms;
   logic [3:0]    w_mm_t, w_mm_o, w_ss_t, w_ss_o, w_ms_t, w_ms_o;
   logic          w_mm_ovf, w_ss_ovf, w_ms_ovf;
   logic [3:0]    w_digit;
   logic          w_ovf;
   logic          w_dp_slot;
   logic          w_hide;
   logic [6:0]    w_seg_on;
   logic          w_dp_on;
   logic [5:0]    w_an_on;

   assign w_tick = (r_presc == SCAN_LAST);

   always_ff @(posedge clk_2MHz or posedge reset) begin
      if (reset) begin
         r_presc      <= '0;
         r_frame_load <= 1'b1;
         r_mm         <= '0;
         r_ss         <= '0;
         r_ms         <= '0;
         r_blink_cnt  <= '0;
         r_blink_hide <= 1'b0;
      end else begin
         r_presc <= w_tick ? '0 : r_presc + 1'b1;
         if (r_frame_load || (w_tick && (r_idx == IDX_5))) begin
            r_mm <= bus.in_mm;
            r_ss <= bus.in_ss;
            r_ms <= bus.in_ms;
         end
         r_frame_load <= 1'b0;
         if (r_blink_cnt == BLINK_LAST) begin
            r_blink_cnt  <= '0;
            r_blink_hide <= ~r_blink_hide;
         end else begin
            r_blink_cnt <= r_blink_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_2MHz or posedge reset) begin
      if (reset) r_idx <= IDX_0;
      else       r_idx <= w_idx_nxt;
   end

   always_comb begin
      w_idx_nxt = r_idx;
      if (w_tick) begin
         case (r_idx)
            IDX_0:   w_idx_nxt = IDX_1;
            IDX_1:   w_idx_nxt = IDX_2;
            IDX_2:   w_idx_nxt = IDX_3;
            IDX_3:   w_idx_nxt = IDX_4;
            IDX_4:   w_idx_nxt = IDX_5;
            default: w_idx_nxt = IDX_0;
         endcase
      end
   end

   // The first cycle after reset shows the live inputs so it agrees with the snapshot being taken
   assign w_mm = r_frame_load ? bus.in_mm : r_mm;
   assign w_ss = r_frame_load ? bus.in_ss : r_ss;
   assign w_ms = r_frame_load ? bus.in_ms : r_ms;

   bin7_to_bcd u_bcd_mm (.i_bin(w_mm), .o_tens(w_mm_t), .o_ones(w_mm_o), .o_ovf(w_mm_ovf));
   bin7_to_bcd u_bcd_ss (.i_bin(w_ss), .o_tens(w_ss_t), .o_ones(w_ss_o), .o_ovf(w_ss_ovf));
   bin7_to_bcd u_bcd_ms (.i_bin(w_ms), .o_tens(w_ms_t), .o_ones(w_ms_o), .o_ovf(w_ms_ovf));

   always_comb begin
      w_digit   = '0;
      w_ovf     = 1'b0;
      w_dp_slot = 1'b0;
      case (r_idx)
         IDX_5: begin w_digit = w_mm_t; w_ovf = w_mm_ovf; end
         IDX_4: begin w_digit = w_mm_o; w_ovf = w_mm_ovf; w_dp_slot = 1'b1; end
         IDX_3: begin w_digit = w_ss_t; w_ovf = w_ss_ovf; end
         IDX_2: begin w_digit = w_ss_o; w_ovf = w_ss_ovf; w_dp_slot = 1'b1; end
         IDX_1: begin w_digit = w_ms_t; w_ovf = w_ms_ovf; end
         default: begin w_digit = w_ms_o; w_ovf = w_ms_ovf; end
      endcase
      // Field of a digit is idx/2, matching the blink_en bit order
      w_hide   = r_blink_hide && bus.blink_en[r_idx[2:1]];
      w_seg_on = w_hide ? SEG_BLANK : (w_ovf ? SEG_DASH : seg_of(w_digit));
      w_dp_on  = w_dp_slot && !w_hide;
      w_an_on  = 6'b000001 << r_idx;
   end

   always_ff @(posedge clk_2MHz or posedge reset) begin
      if (reset) begin
         r_seg <= SEG_OFF;
         r_dp  <= DP_OFF;
         r_an  <= AN_OFF;
      end else begin
         r_seg <= SEG_ACTIVE_LOW ? ~w_seg_on : w_seg_on;
         r_dp  <= SEG_ACTIVE_LOW ? ~w_dp_on  : w_dp_on;
         r_an  <= SEG_ACTIVE_LOW ? ~w_an_on  : w_an_on;
      end
   end

   assign bus.seg = r_seg;
   assign bus.dp  = r_dp;
   assign bus.an  = r_an;

endmodule

// File: tb/tb_stop_display_scan.sv
// Directed bench for stop_display_scan: scan order, snapshot timing, BCD/dash, blink, async reset.
`timescale 1ns/1ps
module tb_stop_display_scan;

   logic clk_2MHz = 1'b0;
   logic reset    = 1'b1;
   int   n_checks = 0;
   int   n_errors = 0;
   int   n_edge   = 0;

   stop_display_scan_if bus ();

   stop_display_scan #(
      .SCAN_DIV       (4),
      .BLINK_DIV      (16),
      .SEG_ACTIVE_LOW (1'b1)
   ) dut (
      .clk_2MHz (clk_2MHz),
      .reset    (reset),
      .bus      (bus)
   );

   always #250 clk_2MHz = ~clk_2MHz;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Active-low pin patterns {g,f,e,d,c,b,a}; 10 stands for the dash
   function automatic logic [6:0] pin_seg(input logic [3:0] d);
      case (d)
         4'd0:    return 7'b1000000;
         4'd1:    return 7'b1111001;
         4'd2:    return 7'b0100100;
         4'd3:    return 7'b0110000;
         4'd4:    return 7'b0011001;
         4'd5:    return 7'b0010010;
         4'd6:    return 7'b0000010;
         4'd7:    return 7'b1111000;
         4'd8:    return 7'b0000000;
         4'd9:    return 7'b0010000;
         4'd10:   return 7'b0111111;
         default: return 7'b1111111;
      endcase
   endfunction

   task automatic step();
      @(posedge clk_2MHz);
      #1;
      n_edge++;
   endtask

   // digs nibble k = digit expected on idx k; inputs are rewritten after the first cycle of chg_slot
   task automatic check_frame(input string tag, input logic [23:0] digs, input int chg_slot,
                              input logic [6:0] mm, input logic [6:0] ss, input logic [6:0] ms);
      logic [5:0] exp_an;
      logic [6:0] exp_seg;
      logic       exp_dp;
      logic       hide;
      for (int k = 0; k < 6; k++) begin
         for (int c = 0; c < 4; c++) begin
            step();
            hide    = ((((n_edge - 1) / 16) % 2) == 1) && bus.blink_en[k / 2];
            exp_an  = ~(6'b000001 << k);
            exp_seg = hide ? 7'b1111111 : pin_seg(digs[4*k +: 4]);
            exp_dp  = ((k == 2 || k == 4) && !hide) ? 1'b0 : 1'b1;
            chk($sformatf("%s an k%0d c%0d", tag, k, c), 32'(bus.an), 32'(exp_an));
            chk($sformatf("%s onehot k%0d c%0d", tag, k, c), 32'($countones(bus.an)), 32'd5);
            chk($sformatf("%s seg k%0d c%0d", tag, k, c), 32'(bus.seg), 32'(exp_seg));
            chk($sformatf("%s dp k%0d c%0d", tag, k, c), 32'(bus.dp), 32'(exp_dp));
            if (k == chg_slot && c == 0) begin
               bus.in_mm = mm;
               bus.in_ss = ss;
               bus.in_ms = ms;
            end
         end
      end
   endtask

   initial begin
      bus.in_mm    = 7'd12;
      bus.in_ss    = 7'd34;
      bus.in_ms    = 7'd56;
      bus.blink_en = 3'b000;
      reset        = 1'b1;
      repeat (2) @(posedge clk_2MHz);
      @(negedge clk_2MHz);
      chk("rst an", 32'(bus.an), 32'h3F);
      chk("rst seg", 32'(bus.seg), 32'h7F);
      chk("rst dp", 32'(bus.dp), 32'h1);
      reset  = 1'b0;
      n_edge = 0;

      check_frame("f0", 24'h123456, -1, 7'd0, 7'd0, 7'd0);
      check_frame("f1", 24'h123456, -1, 7'd0, 7'd0, 7'd0);
      check_frame("f2", 24'h123456, -1, 7'd0, 7'd0, 7'd0);
      check_frame("tear", 24'h123456, 2, 7'd12, 7'd59, 7'd56);
      check_frame("ss59", 24'h125956, 0, 7'd99, 7'd59, 7'd7);
      check_frame("mm99", 24'h995907, 0, 7'd100, 7'd59, 7'd7);
      check_frame("mm100", 24'hAA5907, -1, 7'd0, 7'd0, 7'd0);

      bus.blink_en = 3'b010;
      check_frame("blink0", 24'hAA5907, -1, 7'd0, 7'd0, 7'd0);
      check_frame("blink1", 24'hAA5907, -1, 7'd0, 7'd0, 7'd0);
      check_frame("blink2", 24'hAA5907, -1, 7'd0, 7'd0, 7'd0);
      bus.blink_en = 3'b000;

      // Walk into the middle of idx 3, then hit reset between clock edges
      repeat (14) step();
      chk("pre_rst an", 32'(bus.an), 32'h37);
      #100;
      reset = 1'b1;
      #1;
      chk("async an", 32'(bus.an), 32'h3F);
      chk("async seg", 32'(bus.seg), 32'h7F);
      chk("async dp", 32'(bus.dp), 32'h1);
      bus.in_mm = 7'd5;
      bus.in_ss = 7'd0;
      bus.in_ms = 7'd99;
      @(posedge clk_2MHz);
      #1;
      chk("held an", 32'(bus.an), 32'h3F);
      @(negedge clk_2MHz);
      reset  = 1'b0;
      n_edge = 0;
      check_frame("post_rst", 24'h050099, -1, 7'd0, 7'd0, 7'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/stop_display_scan.md
Name: stop_display_scan

Overview:
- Downstream consumer of the stopwatch mode block's three 7-bit time fields (minutes, seconds, centiseconds; binary 0..99).
- Converts each field to two decimal digits and time-multiplexes them onto a 6-digit common-anode 7-segment display.
- Supports per-field blinking for set/edit indication.
- Sits between the mode/ticker logic and the board pins; all outputs are registered.

Parameters:
- SCAN_DIV, 2000: clk_2MHz cycles per digit slot (1 kHz digit rate, ~167 Hz frame rate).
- BLINK_DIV, 500000: clk_2MHz cycles per blink half-period (250 ms).
- SEG_ACTIVE_LOW, 1: 1 means seg/dp/an are driven low = on; 0 inverts all pin polarity.

Ports:
- clk_2MHz  in  1  system clock, 2 MHz
- reset  in  1  asynchronous, active-high
- in_mm  in  7  minutes field, binary
- in_ss  in  7  seconds field, binary
- in_ms  in  7  centiseconds field, binary
- blink_en  in  3  per-field blink enable: [2]=mm, [1]=ss, [0]=ms
- seg  out  7  segments {g,f,e,d,c,b,a}
- dp  out  1  decimal point
- an  out  6  digit enables; an[5]=mm tens … an[0]=ms ones

Behaviour:
- Reset is asynchronous, active-high; clock is clk_2MHz.
- Reset values:
  - all digits off (an=6'b111111 when SEG_ACTIVE_LOW), seg all off, dp off;
  - prescaler=0, digit index=0, snapshot fields=0;
  - blink counter=0, blink phase=visible;
  - frame_load flag=1.
- Prescaler counts 0..SCAN_DIV-1 and wraps; tick=1 on the cycle it equals SCAN_DIV-1.
- Digit index advances 0→1→…→5→0 on tick.
- Snapshot: the three inputs are latched together on (tick && idx==5), or on the first edge after reset (frame_load, then cleared).
  - Display never tears mid-frame; an input change is visible at the latest one frame later (≤6*SCAN_DIV cycles).
- BCD conversion per field (combinational on the snapshot, compare/subtract chain):
  - values 0..99 give tens = v/10, ones = v%10;
  - values 100..127 give both digits shown as "-" (segment g only).
- Digit mapping: idx5=mm tens, 4=mm ones, 3=ss tens, 2=ss ones, 1=ms tens, 0=ms ones.
- Segment decode: standard 0-9 patterns ("1"=b,c; "7"=a,b,c); no leading-zero blanking.
- dp is lit on idx 4 and 2 (MM.SS.CC separators) and off elsewhere.
- Blink:
  - the blink counter counts 0..BLINK_DIV-1 and toggles the phase at wrap;
  - when the phase is hidden and blink_en bit for the current digit's field is 1, seg and dp are driven off while an stays active;
  - blink_en is sampled live, not snapshotted.
- Output register: an/seg/dp update on every edge from the current idx and snapshot (1-cycle latency from an idx change).
  - Exactly one an bit is active at any time after the first post-reset edge.
- Reset mid-frame: everything returns to reset values immediately; scanning restarts at idx 0 with a fresh snapshot.
- Parameter minimums: SCAN_DIV and BLINK_DIV must be ≥2; smaller values are illegal.

Decomposition:
- Shared package `watch_disp_pkg`:
  - 7-segment pattern constants SEG_0..SEG_9, SEG_DASH, SEG_BLANK;
  - digit-count constant NUM_DIGITS=6.
- One sub-module `bin7_to_bcd` (7-bit in → tens[3:0], ones[3:0], ovf), instantiated three times.
- Prescalers, scan FSM and output logic stay in the top block.

Test Plan:
- Reset release, SCAN_DIV=4, inputs mm=12/ss=34/ms=56, blink_en=0 → an cycles 111110,111101,…,011111, each slot 4 cycles; seg digits read 6,5,4,3,2,1 for idx 0..5; dp low only on idx 2 and 4.
- Change ss from 34 to 59 while idx=2 → idx 2 and 3 still show 4,3 until frame end; next frame shows 9,5.
- in_ms=7 → ms tens shows "0" (a,b,c,d,e,f), ones shows "7"; in_mm=99 shows 9,9; in_mm=100 shows both digits with segment g only.
- blink_en=3'b010, BLINK_DIV=16 → ss digits have seg and dp off for 16-cycle windows alternating with 16 visible cycles; an still strobes; mm/ms unaffected.
- Assert reset asynchronously mid-slot (idx=3) → an/seg/dp go off within the same cycle without a clock edge; after release scanning restarts at idx 0 with the current inputs.
- Count active an bits every cycle over 3 full frames → always exactly 1 after the first post-reset edge.
